// File: rtl/fir_pkg.sv
// Shared constants for the FIR output framer: default widths, saturation
// limits for the default output width and the drop-counter width.
package fir_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int OUT_WIDTH      = 16;
  localparam int DROP_CNT_WIDTH = 16;

  localparam logic signed [OUT_WIDTH-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [OUT_WIDTH-1:0] SAT_MIN = 16'sh8000;

  localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = 16'hFFFF;

endpackage : fir_pkg

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head-of-queue output. The head register
// is loaded on a write into an empty FIFO, so a word written on one edge is
// visible on rd_data in the very next cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_d;
  logic             rd_ok;
  logic             wr_ok;

  assign empty   = (count_q == CW'(0));
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = head_q;

  // Qualify requests and work out the next head word and occupancy.
  always_comb begin
    rd_ok  = rd_en & ~empty;
    wr_ok  = wr_en & (~full | rd_ok);
    head_d = head_q;
    if (rd_ok && wr_ok) begin
      if (count_q == CW'(1)) begin
        head_d = wr_data;
      end else begin
        head_d = mem_q[rd_ptr_q + AW'(1)];
      end
    end else if (rd_ok) begin
      head_d = mem_q[rd_ptr_q + AW'(1)];
    end else if (wr_ok && empty) begin
      head_d = wr_data;
    end else begin
      head_d = head_q;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers, occupancy and head register; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(wr_ok);
      rd_ptr_q <= rd_ptr_q + AW'(rd_ok);
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule : sync_fifo

// File: rtl/fir_out_framer.sv
// Rounds, shifts and saturates decimated FIR samples, buffers them in a FIFO
// and emits them as AXI-Stream frames of FRAME_LEN beats. The FIR side has
// no backpressure, so samples arriving at a full FIFO are dropped and counted.
module fir_out_framer
  import fir_pkg::*;
#(
  parameter int IN_WIDTH   = fir_pkg::DATA_WIDTH,
  parameter int OUT_WIDTH  = fir_pkg::OUT_WIDTH,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_tvalid,
  input  logic [IN_WIDTH-1:0]       s_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [OUT_WIDTH-1:0]      m_tdata,
  output logic                      m_tlast,
  input  logic                      ovf_clr,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  localparam int AW     = IN_WIDTH + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam int BW     = $clog2(FRAME_LEN);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  localparam logic signed [AW-1:0] RND_C    = (SHIFT > 0) ? (AW'(1'b1) << RND_SH) : AW'(1'b0);
  localparam logic signed [AW-1:0] SAT_HI_C = (AW'(1'b1) << (OUT_WIDTH - 1)) - AW'(1'b1);
  localparam logic signed [AW-1:0] SAT_LO_C = -(AW'(1'b1) << (OUT_WIDTH - 1));
  localparam logic [BW-1:0]        LAST_BEAT = BW'(FRAME_LEN - 1);

  logic signed [AW-1:0]      ext_s;
  logic signed [AW-1:0]      rnd_s;
  logic signed [AW-1:0]      shf_s;
  logic [OUT_WIDTH-1:0]      sat_d;
  logic [OUT_WIDTH-1:0]      s1_data_q;
  logic                      s1_valid_q;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CW-1:0]             fifo_count;
  logic                      unused_fifo_count;
  logic                      rd_hs;
  logic                      wr_req;
  logic                      drop;
  logic [BW-1:0]             beat_q;
  logic                      overflow_q;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

  // Sign-extend, round half up, shift and clamp to the output range.
  always_comb begin
    ext_s = {s_tdata[IN_WIDTH-1], s_tdata};
    rnd_s = ext_s + RND_C;
    shf_s = rnd_s >>> SHIFT;
    if (shf_s > SAT_HI_C) begin
      sat_d = SAT_HI_C[OUT_WIDTH-1:0];
    end else if (shf_s < SAT_LO_C) begin
      sat_d = SAT_LO_C[OUT_WIDTH-1:0];
    end else begin
      sat_d = shf_s[OUT_WIDTH-1:0];
    end
  end

  // Stage-1 register holding the conditioned sample for the FIFO write.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s_tvalid;
      s1_data_q  <= s_tvalid ? sat_d : s1_data_q;
    end
  end

  // A full FIFO still accepts a write when a beat leaves in the same cycle.
  assign rd_hs  = m_tvalid & m_tready;
  assign wr_req = s1_valid_q & (~fifo_full | rd_hs);
  assign drop   = s1_valid_q & fifo_full & ~rd_hs;

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_req),
    .wr_data (s1_data_q),
    .rd_en   (rd_hs),
    .rd_data (m_tdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Occupancy is exported by the FIFO but full/empty are all this block needs.
  assign unused_fifo_count = ^fifo_count;

  assign m_tvalid = ~fifo_empty;
  assign m_tlast  = ~fifo_empty & (beat_q == LAST_BEAT);
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  // Beat position within the frame; only delivered beats advance it.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
    end else if (rd_hs) begin
      beat_q <= (beat_q == LAST_BEAT) ? BW'(0) : beat_q + BW'(1);
    end else begin
      beat_q <= beat_q;
    end
  end

  // Sticky overflow and saturating drop count; a clear beats a same-cycle drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      drop_cnt_q <= (drop_cnt_q == DROP_CNT_MAX) ? drop_cnt_q : drop_cnt_q + DROP_CNT_WIDTH'(1);
    end else begin
      overflow_q <= overflow_q;
      drop_cnt_q <= drop_cnt_q;
    end
  end

endmodule : fir_out_framer

// File: tb/tb_fir_out_framer.sv
// Directed bench for fir_out_framer with default parameters.
module tb_fir_out_framer;

  logic        clk;
  logic        rst;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [15:0] m_tdata;
  logic        m_tlast;
  logic        ovf_clr;
  logic        overflow;
  logic [15:0] drop_cnt;

  int n_chk;
  int n_fail;

  logic signed [31:0] vin  [6] = '{32'sd24, -32'sd24, 32'sd7, 32'sd8, 32'sh7FFFFFFF, 32'sh80000000};
  logic signed [31:0] vexp [6] = '{32'sd2, -32'sd1, 32'sd0, 32'sd1, 32'sd32767, -32'sd32768};

  fir_out_framer dut (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .ovf_clr  (ovf_clr),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int v);
    s_tvalid = 1'b1;
    s_tdata  = 32'(v);
    tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tvalid"}, 32'(m_tvalid), 32'sd0);
    chk({tag, "_tlast"}, 32'(m_tlast), 32'sd0);
    chk({tag, "_tdata"}, 32'($signed(m_tdata)), 32'sd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'sd0);
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'sd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = 32'd0;
    m_tready = 1'b0;
    ovf_clr  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_idle("reset");

    // Rounding and saturation, one sample at a time, 2-cycle latency.
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = vin[i];
      tick();
      s_tvalid = 1'b0;
      tick();
      chk("round_tvalid", 32'(m_tvalid), 32'sd1);
      chk("round_tdata", 32'($signed(m_tdata)), vexp[i]);
      chk("round_tlast", 32'(m_tlast), 32'sd0);
      tick();
      chk("round_drained", 32'(m_tvalid), 32'sd0);
    end

    // Backpressure: 20 samples into a 16-deep FIFO, 4 dropped.
    m_tready = 1'b0;
    for (int i = 1; i <= 20; i++) push(i * 16);
    s_tvalid = 1'b0;
    tick();
    tick();
    chk("bp_overflow", 32'(overflow), 32'sd1);
    chk("bp_drop_cnt", 32'(drop_cnt), 32'sd4);
    chk("bp_hold_tvalid", 32'(m_tvalid), 32'sd1);
    chk("bp_hold_tdata", 32'($signed(m_tdata)), 32'sd1);
    m_tready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("bp_out_tvalid", 32'(m_tvalid), 32'sd1);
      chk("bp_out_tdata", 32'($signed(m_tdata)), 32'(i));
      chk("bp_out_tlast", 32'(m_tlast), 32'sd0);
      tick();
    end
    chk("bp_empty", 32'(m_tvalid), 32'sd0);

    // Clear of a nonzero drop count.
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_overflow", 32'(overflow), 32'sd0);
    chk("clr_drop_cnt", 32'(drop_cnt), 32'sd0);

    // Reset with 5 samples buffered and one sample in flight.
    m_tready = 1'b0;
    for (int i = 1; i <= 5; i++) push(i * 16);
    s_tvalid = 1'b0;
    tick();
    tick();
    chk("pre_rst_tvalid", 32'(m_tvalid), 32'sd1);
    rst      = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 32'd1584;
    tick();
    rst      = 1'b0;
    s_tvalid = 1'b0;
    chk_idle("mid_rst");

    // Framing: 130 back-to-back samples starting right after reset.
    for (int n = 0; n < 132; n++) begin
      m_tready = 1'b1;
      s_tvalid = (n < 130);
      s_tdata  = 32'((n + 1) * 16);
      if (n < 2) begin
        chk("frame_lat_tvalid", 32'(m_tvalid), 32'sd0);
      end else begin
        chk("frame_tvalid", 32'(m_tvalid), 32'sd1);
        chk("frame_tdata", 32'($signed(m_tdata)), 32'(n - 1));
        chk("frame_tlast", 32'(m_tlast), ((n - 2) == 63 || (n - 2) == 127) ? 32'sd1 : 32'sd0);
      end
      tick();
    end
    s_tvalid = 1'b0;
    chk("frame_empty", 32'(m_tvalid), 32'sd0);

    // Simultaneous read and write at full for 10 cycles.
    m_tready = 1'b0;
    for (int i = 1; i <= 16; i++) push(i * 16);
    s_tvalid = 1'b0;
    tick();
    tick();
    chk("rw_full_tvalid", 32'(m_tvalid), 32'sd1);
    chk("rw_full_overflow", 32'(overflow), 32'sd0);
    s_tvalid = 1'b1;
    s_tdata  = 32'd272;
    tick();
    for (int c = 0; c < 26; c++) begin
      m_tready = 1'b1;
      s_tvalid = (c < 9);
      s_tdata  = 32'((18 + c) * 16);
      chk("rw_tvalid", 32'(m_tvalid), 32'sd1);
      chk("rw_tdata", 32'($signed(m_tdata)), 32'(c + 1));
      tick();
    end
    s_tvalid = 1'b0;
    chk("rw_empty", 32'(m_tvalid), 32'sd0);
    chk("rw_drop_cnt", 32'(drop_cnt), 32'sd0);
    chk("rw_overflow", 32'(overflow), 32'sd0);

    // Clear coinciding with a drop: the clear wins.
    m_tready = 1'b0;
    for (int i = 0; i < 18; i++) push((i + 1) * 16);
    s_tvalid = 1'b0;
    chk("race_pre_overflow", 32'(overflow), 32'sd1);
    chk("race_pre_drop_cnt", 32'(drop_cnt), 32'sd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("race_overflow", 32'(overflow), 32'sd0);
    chk("race_drop_cnt", 32'(drop_cnt), 32'sd0);
    tick();
    chk("race_drop_hold", 32'(drop_cnt), 32'sd0);
    m_tready = 1'b1;
    chk("race_head", 32'($signed(m_tdata)), 32'sd1);
    for (int i = 0; i < 16; i++) tick();
    chk("race_empty", 32'(m_tvalid), 32'sd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_fir_out_framer
